// File: rtl/axi_wr_slave_endpoint_pkg.sv
// Shared types and widths for the AXI write-slave endpoint.
// Bus widths, queue entry layout, response codes and W FSM states.
package axi_wr_slave_endpoint_pkg;

  localparam int PID_WIDTH     = 4;
  localparam int PADDR_WIDTH   = 32;
  localparam int PLENGTH_WIDTH = 8;
  localparam int PSIZE_WIDTH   = 3;
  localparam int PDATA_WIDTH   = 4;
  localparam int POP_WIDTH     = $clog2(PDATA_WIDTH + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [PID_WIDTH-1:0]     awid;
    logic [PADDR_WIDTH-1:0]   awaddr;
    logic [PLENGTH_WIDTH-1:0] awlen;
    logic [PSIZE_WIDTH-1:0]   awsize;
  } wr_aw_entry_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BURST,
    W_RESP
  } w_state_t;

  function automatic logic [POP_WIDTH-1:0] popcount(
    input logic [PDATA_WIDTH-1:0] v
  );
    logic [POP_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < PDATA_WIDTH; i++)
      n = n + POP_WIDTH'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/axi_wr_slave_endpoint_if.sv
// AW/W/B channel bundle between the slave-side FIFOs and the endpoint.
// master drives requests and bready; slave drives readies and B.
interface axi_wr_slave_endpoint_if;
  import axi_wr_slave_endpoint_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [PID_WIDTH-1:0]     awid;
  logic [PADDR_WIDTH-1:0]   awaddr;
  logic [PLENGTH_WIDTH-1:0] awlen;
  logic [PSIZE_WIDTH-1:0]   awsize;

  logic                     wvalid;
  logic                     wready;
  logic [PID_WIDTH-1:0]     wid;
  logic [8*PDATA_WIDTH-1:0] wdata;
  logic [PDATA_WIDTH-1:0]   wstrb;
  logic                     wlast;

  logic                     bvalid;
  logic                     bready;
  logic [PID_WIDTH-1:0]     bid;
  logic [1:0]               bresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bid, bresp
  );

endinterface

// File: rtl/axi_wr_slave_endpoint_aw_queue.sv
// Synchronous FIFO of accepted AW bursts with active-high sync reset.
// Extra pointer bit distinguishes full from empty.
module wr_aw_queue
  import axi_wr_slave_endpoint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  wr_aw_entry_t din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output wr_aw_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  wr_aw_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axi_wr_slave_endpoint.sv
// AXI write-slave endpoint: queues AW, drains W against the head burst,
// checks ID/length and returns one B per burst, with statistics.
module axi_wr_slave_endpoint
  import axi_wr_slave_endpoint_pkg::*;
#(
  parameter int AWQ_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_wr_slave_endpoint_if.slave bus,
  output logic [CNT_WIDTH-1:0] burst_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] byte_cnt
);

  localparam int BW = PLENGTH_WIDTH + 1;

  w_state_t       state;
  wr_aw_entry_t   aw_in;
  wr_aw_entry_t   head;
  logic           q_full;
  logic           q_empty;
  logic           aw_push;
  logic           w_fire;
  logic           b_fire;

  logic           wready_q;
  logic           bvalid_q;
  logic [PID_WIDTH-1:0] bid_q;
  logic [1:0]     bresp_q;

  logic [BW-1:0]  beat_cnt;
  logic [BW-1:0]  len_ext;
  logic           err_flag;
  logic           id_err;
  logic           last_err;
  logic           over_err;
  logic           err_next;

  // Readies held low through reset so nothing is accepted mid-reset.
  assign bus.awready = ~q_full & ~rst;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;

  assign aw_push = bus.awvalid & bus.awready;
  assign w_fire  = bus.wvalid & wready_q;
  assign b_fire  = bvalid_q & bus.bready;

  assign aw_in.awid   = bus.awid;
  assign aw_in.awaddr = bus.awaddr;
  assign aw_in.awlen  = bus.awlen;
  assign aw_in.awsize = bus.awsize;

  wr_aw_queue #(
    .DEPTH (AWQ_DEPTH)
  ) u_awq (
    .clk   (clk),
    .rst   (rst),
    .push  (aw_push),
    .din   (aw_in),
    .pop   (b_fire),
    .full  (q_full),
    .empty (q_empty),
    .head  (head)
  );

  // Per-beat checks against the head burst; beat_cnt is the beat index.
  assign len_ext  = {1'b0, head.awlen};
  assign id_err   = (bus.wid != head.awid);
  assign last_err = bus.wlast && (beat_cnt != len_ext);
  assign over_err = !bus.wlast && (beat_cnt > len_ext);
  assign err_next = err_flag | id_err | last_err | over_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= W_IDLE;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      beat_cnt  <= '0;
      err_flag  <= 1'b0;
      burst_cnt <= '0;
      err_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      if (w_fire)
        byte_cnt <= byte_cnt +
                    CNT_WIDTH'(popcount(bus.wstrb));
      unique case (state)
        W_IDLE: begin
          if (!q_empty) begin
            state    <= W_BURST;
            wready_q <= 1'b1;
            beat_cnt <= '0;
            err_flag <= 1'b0;
          end
        end
        W_BURST: begin
          if (w_fire) begin
            if (beat_cnt != '1)
              beat_cnt <= beat_cnt + 1'b1;
            err_flag <= err_next;
            if (bus.wlast) begin
              state    <= W_RESP;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= head.awid;
              bresp_q  <= err_next ? RESP_SLVERR
                                   : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (b_fire) begin
            state     <= W_IDLE;
            bvalid_q  <= 1'b0;
            burst_cnt <= burst_cnt + 1'b1;
            if (bresp_q == RESP_SLVERR &&
                err_cnt != '1)
              err_cnt <= err_cnt + 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.wdata, head.awaddr, head.awsize};

endmodule

// File: tb/tb_axi_wr_slave_endpoint.sv
// Directed self-checking bench for axi_wr_slave_endpoint.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_wr_slave_endpoint;
  import axi_wr_slave_endpoint_pkg::*;

  localparam int CW  = 16;
  localparam int TMO = 100;

  logic          clk;
  logic          rst;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] byte_cnt;

  int n_checks;
  int n_errors;
  logic b1_done;

  axi_wr_slave_endpoint_if bus();

  axi_wr_slave_endpoint #(
    .AWQ_DEPTH (4),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .burst_cnt (burst_cnt),
    .err_cnt   (err_cnt),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic aw_push(input logic [3:0] id,
                         input logic [7:0] len);
    int t;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awaddr  = {24'h0, id, 4'h0};
    bus.awlen   = len;
    bus.awsize  = 3'd2;
    t = 0;
    while (!bus.awready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check("aw_tmo", bus.awready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [3:0] id,
                        input logic [3:0] strb,
                        input logic last);
    int t;
    bus.wvalid = 1'b1;
    bus.wid    = id;
    bus.wdata  = {8{id}};
    bus.wstrb  = strb;
    bus.wlast  = last;
    t = 0;
    while (!bus.wready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check("w_tmo", bus.wready, 1);
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_take(output logic [3:0] id,
                        output logic [1:0] resp);
    int t;
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) check("b_tmo", bus.bvalid, 1);
    id   = bus.bid;
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  logic [3:0] rid;
  logic [1:0] rresp;

  initial begin
    n_checks = 0;
    n_errors = 0;
    b1_done  = 1'b0;
    rst = 1'b1;
    bus.awvalid = 1'b0;
    bus.awid    = '0;
    bus.awaddr  = '0;
    bus.awlen   = '0;
    bus.awsize  = '0;
    bus.wvalid  = 1'b0;
    bus.wid     = '0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_burst", burst_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_byte", byte_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_awready", bus.awready, 1);

    // 1: clean 4-beat burst
    aw_push(4'd3, 8'd3);
    check("t1_wready_n1", bus.wready, 0);
    @(negedge clk);
    check("t1_wready_n2", bus.wready, 1);
    for (int i = 0; i < 4; i++)
      w_beat(4'd3, 4'hF, i == 3);
    check("t1_bvalid", bus.bvalid, 1);
    check("t1_wready_off", bus.wready, 0);
    check("t1_bid", bus.bid, 3);
    check("t1_bresp", bus.bresp, RESP_OKAY);
    b_take(rid, rresp);
    check("t1_burst", burst_cnt, 1);
    check("t1_byte", byte_cnt, 16);
    check("t1_err", err_cnt, 0);

    // 2: early wlast, then a clean burst
    aw_push(4'd1, 8'd3);
    w_beat(4'd1, 4'h3, 1'b0);
    w_beat(4'd1, 4'h3, 1'b1);
    b_take(rid, rresp);
    check("t2_bid", rid, 1);
    check("t2_bresp", rresp, RESP_SLVERR);
    check("t2_err", err_cnt, 1);
    check("t2_burst", burst_cnt, 2);
    aw_push(4'd2, 8'd0);
    w_beat(4'd2, 4'h1, 1'b1);
    b_take(rid, rresp);
    check("t2b_bid", rid, 2);
    check("t2b_bresp", rresp, RESP_OKAY);
    check("t2b_byte", byte_cnt, 21);
    check("t2b_err", err_cnt, 1);

    // 3: ID mismatch
    aw_push(4'd5, 8'd0);
    w_beat(4'd6, 4'hF, 1'b1);
    b_take(rid, rresp);
    check("t3_bid", rid, 5);
    check("t3_bresp", rresp, RESP_SLVERR);
    check("t3_err", err_cnt, 2);

    // 4: fill the queue, fifth AW waits for first B
    for (int i = 0; i < 4; i++)
      aw_push(4'(7 + i), 8'd0);
    check("t4_full", bus.awready, 0);
    fork
      begin
        aw_push(4'd11, 8'd0);
        check("t4_aw5_after_b", b1_done, 1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          w_beat(4'(7 + i), 4'hF, 1'b1);
          b_take(rid, rresp);
          if (i == 0) b1_done = 1'b1;
          check("t4_bid_order", rid, 7 + i);
          check("t4_bresp", rresp, RESP_OKAY);
        end
      end
    join
    check("t4_burst", burst_cnt, 9);
    check("t4_byte", byte_cnt, 45);

    // 5: B backpressure
    aw_push(4'd4, 8'd0);
    w_beat(4'd4, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t5_bvalid", bus.bvalid, 1);
      check("t5_bid", bus.bid, 4);
      check("t5_bresp", bus.bresp, RESP_OKAY);
      check("t5_wready", bus.wready, 0);
      @(negedge clk);
    end
    check("t5_burst_hold", burst_cnt, 9);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("t5_bvalid_off", bus.bvalid, 0);
    check("t5_burst", burst_cnt, 10);
    check("t5_byte", byte_cnt, 49);

    // 6: reset in the middle of a burst
    aw_push(4'd6, 8'd3);
    w_beat(4'd6, 4'hF, 1'b0);
    w_beat(4'd6, 4'hF, 1'b0);
    check("t6_byte_pre", byte_cnt, 57);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_burst", burst_cnt, 0);
    check("t6_err", err_cnt, 0);
    check("t6_byte", byte_cnt, 0);
    check("t6_bvalid", bus.bvalid, 0);
    check("t6_wready", bus.wready, 0);
    check("t6_awready", bus.awready, 1);
    aw_push(4'd1, 8'd0);
    w_beat(4'd1, 4'h3, 1'b1);
    b_take(rid, rresp);
    check("t6_post_bid", rid, 1);
    check("t6_post_bresp", rresp, RESP_OKAY);
    check("t6_post_burst", burst_cnt, 1);
    check("t6_post_byte", byte_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
